// File: rtl/sdram_init_sequencer_pkg.sv
// sdram_init_sequencer_pkg
// Shared definitions for the SDRAM power-up sequencer:
//   - default address width
//   - 3-bit command encodings used on the control-interface command port
//   - FSM state encoding
//   - width of the shared wait/timeout down-counter
//   - step_cmd(): the command issued in each issue state
package sdram_init_sequencer_pkg;

  localparam int ASIZE_DEFAULT = 23;
  localparam int CNT_W         = 16;

  localparam logic [2:0] CMD_NOP       = 3'b000;
  localparam logic [2:0] CMD_READA     = 3'b001;
  localparam logic [2:0] CMD_WRITEA    = 3'b010;
  localparam logic [2:0] CMD_REFRESH   = 3'b011;
  localparam logic [2:0] CMD_PRECHARGE = 3'b100;
  localparam logic [2:0] CMD_LOAD_MODE = 3'b101;
  localparam logic [2:0] CMD_LOAD_REG1 = 3'b110;
  localparam logic [2:0] CMD_LOAD_REG2 = 3'b111;

  typedef enum logic [3:0] {
    ST_WAIT = 4'd0,
    ST_REG1 = 4'd1,
    ST_REG2 = 4'd2,
    ST_PRE  = 4'd3,
    ST_REF  = 4'd4,
    ST_MODE = 4'd5,
    ST_GAP  = 4'd6,
    ST_DONE = 4'd7,
    ST_ERR  = 4'd8
  } state_t;

  function automatic logic [2:0] step_cmd(input state_t s);
    case (s)
      ST_REG1: step_cmd = CMD_LOAD_REG1;
      ST_REG2: step_cmd = CMD_LOAD_REG2;
      ST_PRE:  step_cmd = CMD_PRECHARGE;
      ST_REF:  step_cmd = CMD_REFRESH;
      ST_MODE: step_cmd = CMD_LOAD_MODE;
      default: step_cmd = CMD_NOP;
    endcase
  endfunction

endpackage

// File: rtl/sdram_init_sequencer_init_wait_counter.sv
// init_wait_counter
// Loadable down-counter that saturates at zero and flags it.
// Ports:
//   i_clk       clock
//   i_rst_n     asynchronous active-low reset (count <= RESET_VAL)
//   i_load      load i_load_val (has priority over decrement)
//   i_load_val  value to load
//   i_en        decrement by one while non-zero
//   o_zero      count is zero
module init_wait_counter
  import sdram_init_sequencer_pkg::*;
#(
  parameter int               WIDTH     = CNT_W,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= RESET_VAL;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/sdram_init_sequencer.sv
// sdram_init_sequencer
// Runs the SDRAM power-up sequence on the control-interface command port
// (wait, LOAD_REG1, LOAD_REG2, PRECHARGE, N x REFRESH, LOAD_MODE), then
// hands the port to the host and raises o_init_done.
// Optional feature macro: INIT_TIMEOUT_EN (ack timeout -> ERR, o_init_err).
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_host_cmd/addr       host command/address (passed through once done)
//   i_cmd_ack             one-cycle acknowledge from the control interface
//   o_cmd/o_addr          command/address to the control interface
//   o_host_cmd_ack        acknowledge to host (only once done)
//   o_init_done           sequence complete
//   o_init_err            ack timeout seen (0 without INIT_TIMEOUT_EN)
//
// state | meaning
// WAIT  | power-up idle, counting INIT_WAIT cycles
// REG1  | LOAD_REG1 held until ack
// REG2  | LOAD_REG2 held until ack
// PRE   | PRECHARGE held until ack
// REF   | REFRESH held until ack, repeated INIT_REFRESHES times
// MODE  | LOAD_MODE held until ack
// GAP   | one NOP cycle between commands, then load r_next
// DONE  | host owns the command port (terminal)
// ERR   | ack timeout (terminal, INIT_TIMEOUT_EN only)
module sdram_init_sequencer
  import sdram_init_sequencer_pkg::*;
#(
  parameter int          ASIZE          = ASIZE_DEFAULT,
  parameter int          INIT_WAIT      = 10000,
  parameter logic [15:0] REG1_VAL       = 16'h0316,
  parameter logic [15:0] REG2_VAL       = 16'd1562,
  parameter logic [15:0] MODE_VAL       = 16'h0037,
  parameter int          INIT_REFRESHES = 8,
  parameter int          ACK_TIMEOUT    = 1023
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [2:0]       i_host_cmd,
  input  logic [ASIZE-1:0] i_host_addr,
  input  logic             i_cmd_ack,
  output logic [2:0]       o_cmd,
  output logic [ASIZE-1:0] o_addr,
  output logic             o_host_cmd_ack,
  output logic             o_init_done,
  output logic             o_init_err
);

  localparam logic [CNT_W-1:0] WAIT_RELOAD = CNT_W'(INIT_WAIT - 1);
  localparam logic [CNT_W-1:0] ACK_RELOAD  = CNT_W'(ACK_TIMEOUT - 1);

  state_t           r_state;
  state_t           r_next;
  logic [3:0]       r_ref_cnt;
  logic [2:0]       r_cmd;
  logic [ASIZE-1:0] r_addr;
  logic             r_init_done;

  state_t     w_after;
  logic [3:0] w_ref_inc;
  logic       w_cnt_zero;
  logic       w_cnt_load;
  logic       w_cnt_en;
  logic       w_issue;

  function automatic logic [ASIZE-1:0] step_addr(input state_t s);
    case (s)
      ST_REG1: step_addr = ASIZE'(REG1_VAL);
      ST_REG2: step_addr = ASIZE'(REG2_VAL);
      ST_MODE: step_addr = ASIZE'(MODE_VAL);
      default: step_addr = '0;
    endcase
  endfunction

  assign w_issue   = (r_state == ST_REG1) || (r_state == ST_REG2) ||
                     (r_state == ST_PRE)  || (r_state == ST_REF)  ||
                     (r_state == ST_MODE);
  assign w_ref_inc = r_ref_cnt + 4'd1;

  always_comb begin
    w_after = ST_DONE;
    case (r_state)
      ST_REG1: w_after = ST_REG2;
      ST_REG2: w_after = ST_PRE;
      ST_PRE:  w_after = ST_REF;
      ST_REF:  w_after = (w_ref_inc == 4'(INIT_REFRESHES)) ? ST_MODE : ST_REF;
      default: w_after = ST_DONE;
    endcase
  end

  // One counter serves the power-up wait and, when enabled, the ack timeout;
  // it is reloaded on every entry into an issue state (WAIT exit or GAP).
`ifdef INIT_TIMEOUT_EN
  assign w_cnt_load = ((r_state == ST_WAIT) && w_cnt_zero) || (r_state == ST_GAP);
  assign w_cnt_en   = (r_state == ST_WAIT) || w_issue;
`else
  assign w_cnt_load = 1'b0;
  assign w_cnt_en   = (r_state == ST_WAIT);
`endif

  init_wait_counter #(
    .WIDTH     (CNT_W),
    .RESET_VAL (WAIT_RELOAD)
  ) u_wait_cnt (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (w_cnt_load),
    .i_load_val (ACK_RELOAD),
    .i_en       (w_cnt_en),
    .o_zero     (w_cnt_zero)
  );

`ifdef INIT_TIMEOUT_EN
  logic r_init_err;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_WAIT;
      r_next      <= ST_REG1;
      r_ref_cnt   <= '0;
      r_cmd       <= CMD_NOP;
      r_addr      <= '0;
      r_init_done <= 1'b0;
`ifdef INIT_TIMEOUT_EN
      r_init_err  <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_WAIT: begin
          if (w_cnt_zero) begin
            r_state <= ST_REG1;
            r_cmd   <= CMD_LOAD_REG1;
            r_addr  <= step_addr(ST_REG1);
          end
        end
        ST_REG1, ST_REG2, ST_PRE, ST_REF, ST_MODE: begin
          // ack wins over a timeout expiring on the same edge
          if (i_cmd_ack) begin
            r_cmd   <= CMD_NOP;
            r_state <= ST_GAP;
            r_next  <= w_after;
            if (r_state == ST_REF) r_ref_cnt <= w_ref_inc;
          end
`ifdef INIT_TIMEOUT_EN
          else if (w_cnt_zero) begin
            r_state    <= ST_ERR;
            r_cmd      <= CMD_NOP;
            r_init_err <= 1'b1;
          end
`endif
        end
        ST_GAP: begin
          r_state <= r_next;
          r_cmd   <= step_cmd(r_next);
          r_addr  <= step_addr(r_next);
          if (r_next == ST_DONE) r_init_done <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // Host pass-through is combinational so DONE adds no latency.
  assign o_cmd          = (r_state == ST_DONE) ? i_host_cmd  : r_cmd;
  assign o_addr         = (r_state == ST_DONE) ? i_host_addr : r_addr;
  assign o_host_cmd_ack = (r_state == ST_DONE) && i_cmd_ack;
  assign o_init_done    = r_init_done;
`ifdef INIT_TIMEOUT_EN
  assign o_init_err     = r_init_err;
`else
  assign o_init_err     = 1'b0;
`endif

endmodule

// File: tb/tb_sdram_init_sequencer.sv
module tb_sdram_init_sequencer;
  import sdram_init_sequencer_pkg::*;

  localparam int AW     = 16;
  localparam int IW     = 20;
  localparam int BUDGET = 2000;

  typedef struct {
    logic [2:0]    cmd;
    logic [AW-1:0] addr;
    int            len;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n, rst1_n;
  logic [2:0]    host_cmd;
  logic [AW-1:0] host_addr;
  logic          ack, ack1;
  logic [2:0]    o_cmd, o_cmd1;
  logic [AW-1:0] o_addr, o_addr1;
  logic          o_hack, o_hack1, o_done, o_done1, o_err, o_err1;
  logic [2:0]    h1_cmd  = 3'b000;
  logic [AW-1:0] h1_addr = '0;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   age = 0;
  int   dly [8];
  bit   ack_auto = 0;
  bit   skip_reg2 = 0;
  logic [2:0] prev1 = 3'b000;
  exp_t exp_q[$];
  logic [2:0] q1[$];

  always #5 clk = ~clk;

  sdram_init_sequencer #(
    .ASIZE(AW), .INIT_WAIT(IW), .INIT_REFRESHES(8), .ACK_TIMEOUT(100)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_host_cmd(host_cmd), .i_host_addr(host_addr),
    .i_cmd_ack(ack), .o_cmd(o_cmd), .o_addr(o_addr), .o_host_cmd_ack(o_hack),
    .o_init_done(o_done), .o_init_err(o_err)
  );

  sdram_init_sequencer #(
    .ASIZE(AW), .INIT_WAIT(IW), .INIT_REFRESHES(1), .ACK_TIMEOUT(15)
  ) dut1 (
    .i_clk(clk), .i_rst_n(rst1_n), .i_host_cmd(h1_cmd), .i_host_addr(h1_addr),
    .i_cmd_ack(ack1), .o_cmd(o_cmd1), .o_addr(o_addr1), .o_host_cmd_ack(o_hack1),
    .o_init_done(o_done1), .o_init_err(o_err1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Samples at the negedge, then drives the acks for the next posedge.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (o_cmd1 != CMD_NOP && o_cmd1 != prev1 && !o_done1) q1.push_back(o_cmd1);
    ack1 = !o_done1 && (o_cmd1 != CMD_NOP) && (o_cmd1 == prev1) &&
           !(skip_reg2 && o_cmd1 == CMD_LOAD_REG2);
    prev1 = o_cmd1;
    if (ack_auto) begin
      if (o_cmd != CMD_NOP && !o_done) age++; else age = 0;
      ack = (age != 0) && (dly[o_cmd] != 0) && (age == dly[o_cmd]);
    end
  endtask

  task automatic push_exp(input logic [2:0] c, input logic [AW-1:0] a, input int l);
    exp_t e;
    e.cmd = c; e.addr = a; e.len = l;
    exp_q.push_back(e);
  endtask

  // Runs from reset release; returns early when REFRESH number abort_ref appears.
  task automatic run_init(input int abort_ref, output bit aborted);
    int n, run, nops, refs, cur_len, leak, hold_viol;
    logic [2:0]    prev;
    logic [AW-1:0] held;
    bit first;
    exp_t e;
    exp_q.delete();
    push_exp(CMD_LOAD_REG1, 16'h0316, dly[6]);
    push_exp(CMD_LOAD_REG2, 16'h061A, dly[7]);
    push_exp(CMD_PRECHARGE, 16'h0000, dly[4]);
    for (int i = 0; i < 8; i++) push_exp(CMD_REFRESH, 16'h0000, dly[3]);
    push_exp(CMD_LOAD_MODE, 16'h0037, dly[5]);
    n = 0; run = 0; nops = 0; refs = 0; cur_len = 0; leak = 0; hold_viol = 0;
    prev = CMD_NOP; held = '0; first = 1; aborted = 0; age = 0;
    while (n < BUDGET) begin
      tick();
      n++;
      if (o_done) break;
      if (o_hack !== 1'b0 || o_cmd == CMD_READA) leak++;
      if (o_cmd != CMD_NOP) begin
        if (o_cmd != prev) begin
          if (first) chk("first_issue_cycle", n, IW);
          else       chk("gap_len", nops, 1);
          first = 0;
          if (exp_q.size() == 0) chk("extra_cmd", o_cmd, CMD_NOP);
          else begin
            e = exp_q.pop_front();
            chk("cmd", o_cmd, e.cmd);
            chk("addr", o_addr, e.addr);
            cur_len = e.len;
          end
          run = 1; held = o_addr;
          if (o_cmd == CMD_REFRESH) begin
            refs++;
            if (refs == abort_ref) begin
              aborted = 1;
              chk("init_host_leak", leak, 0);
              return;
            end
          end
        end else begin
          run++;
          if (o_addr != held) hold_viol++;
        end
        nops = 0;
      end else begin
        if (prev != CMD_NOP) chk("issue_len", run, cur_len);
        nops++;
      end
      prev = o_cmd;
    end
    chk("done_reached", o_done, 1'b1);
    chk("done_one_gap", nops, 1);
    chk("queue_empty", exp_q.size(), 0);
    chk("init_host_leak", leak, 0);
    chk("addr_hold", hold_viol, 0);
  endtask

  logic [2:0]    pc [4] = '{3'b001, 3'b010, 3'b011, 3'b111};
  logic [AW-1:0] pa [4] = '{16'h1234, 16'hBEEF, 16'h0000, 16'hFFFF};
  logic          pk [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic [2:0]    exp1 [5] = '{CMD_LOAD_REG1, CMD_LOAD_REG2, CMD_PRECHARGE, CMD_REFRESH, CMD_LOAD_MODE};

  initial begin
    bit ab;
    int n, r2;
    for (int i = 0; i < 8; i++) dly[i] = 2;
    rst_n = 0; rst1_n = 0;
    host_cmd = CMD_READA; host_addr = 16'h1234;
    ack = 1; ack1 = 0;
    tick(); tick();
    chk("rst_cmd", o_cmd, 3'b000);
    chk("rst_addr", o_addr, 16'h0000);
    chk("rst_hack", o_hack, 1'b0);
    chk("rst_done", o_done, 1'b0);
    chk("rst_err", o_err, 1'b0);

    // full sequence, PRECHARGE ack held off 50 cycles
    ack = 0; dly[4] = 51; ack_auto = 1;
    rst_n = 1; rst1_n = 1;
    run_init(0, ab);

    // dut1: single refresh
    chk("r1_done", o_done1, 1'b1);
    chk("r1_count", q1.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < q1.size()) chk("r1_order", q1[i], exp1[i]);
    end

    // host pass-through in DONE
    ack_auto = 0;
    for (int i = 0; i < 4; i++) begin
      host_cmd = pc[i]; host_addr = pa[i]; ack = pk[i];
      #1;
      chk("pass_cmd", o_cmd, pc[i]);
      chk("pass_addr", o_addr, pa[i]);
      chk("pass_hack", o_hack, pk[i]);
      tick();
      chk("done_sticky", o_done, 1'b1);
    end

    // reset during the 4th REFRESH, then full restart
    host_cmd = CMD_READA; host_addr = 16'h1234; ack = 0;
    rst_n = 0; tick(); rst_n = 1;
    dly[4] = 2; ack_auto = 1;
    run_init(4, ab);
    chk("abort_reached", ab, 1'b1);
    rst_n = 0; ack = 1;
    #1;
    chk("midrst_cmd", o_cmd, 3'b000);
    chk("midrst_addr", o_addr, 16'h0000);
    chk("midrst_hack", o_hack, 1'b0);
    chk("midrst_done", o_done, 1'b0);
    tick(); tick();
    ack = 0;
    rst_n = 1;
    run_init(0, ab);

    // dut1: LOAD_REG2 never acked
    skip_reg2 = 1; rst1_n = 0; tick(); q1.delete(); rst1_n = 1;
    n = 0; r2 = 0;
    while (n < 200 && !o_err1) begin
      tick(); n++;
      if (o_cmd1 == CMD_LOAD_REG2) r2++;
    end
`ifdef INIT_TIMEOUT_EN
    chk("to_err", o_err1, 1'b1);
    chk("to_reg2_cycles", r2, 15);
    chk("to_cmd", o_cmd1, CMD_NOP);
    chk("to_done", o_done1, 1'b0);
    tick(); tick();
    chk("to_err_sticky", o_err1, 1'b1);
    rst1_n = 0;
    #1;
    chk("to_err_cleared", o_err1, 1'b0);
`else
    chk("noto_err", o_err1, 1'b0);
    chk("noto_waits", o_cmd1, CMD_LOAD_REG2);
    chk("noto_done", o_done1, 1'b0);
    chk("noto_main_err", o_err, 1'b0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
